div_32bit_seq: RTL and testbench

- Sequential signed 32-bit integer divider for the ALU DIV operation.
- Iterative restoring division on operand magnitudes: one trial subtraction per clock using a 33-bit internal subtract path, followed by a sign-correction step.
- Sits between the ALU operand registers (Ra, Rb) and the HI/LO result registers.
- Quotient feeds LO; remainder feeds HI.

---
 rtl/div_32bit_seq_if.sv | 24 ++
 rtl/div_32bit_seq.sv | 117 +++++++++++
 tb/tb_div_32bit_seq.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/div_32bit_seq_if.sv
// Handshake and operand/result bundle between the ALU operand registers
// and the sequential divider; master drives requests, slave returns results.
interface div_32bit_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] Ra;
  logic [WIDTH-1:0] Rb;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, Ra, Rb,
    input  busy, done, div_zero, quotient, remainder
  );

  modport slave (
    input  start, Ra, Rb,
    output busy, done, div_zero, quotient, remainder
  );
endinterface

// File: rtl/div_32bit_seq.sv
// Sequential signed divider: restoring division on operand magnitudes, one
// quotient bit per clock, then a sign-correction step. Quotient -> LO, remainder -> HI.
module div_32bit_seq #(
  parameter int unsigned WIDTH = 32
) (
  input logic               clk,
  input logic               clr,
  div_32bit_seq_if.slave    bus
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] dvd_q;   // dividend magnitude, becomes the quotient magnitude
  logic [WIDTH-1:0] dvs_q;   // divisor magnitude
  // Partial remainder stays below the divisor, so WIDTH bits hold it; the
  // extra bit only exists on the shifted/trial subtract path.
  logic [WIDTH-1:0] p_q;
  logic             sq_q;
  logic             sr_q;

  logic             busy_q;
  logic             done_q;
  logic             div_zero_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;

  logic [WIDTH-1:0] ra_mag;
  logic [WIDTH-1:0] rb_mag;
  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   p_trial;
  logic             trial_ok;

  // 32'h80000000 negates to itself and reads correctly as unsigned 2^31.
  always_comb begin
    ra_mag   = bus.Ra[WIDTH-1] ? -bus.Ra : bus.Ra;
    rb_mag   = bus.Rb[WIDTH-1] ? -bus.Rb : bus.Rb;
    p_shift  = {p_q, dvd_q[WIDTH-1]};
    p_trial  = p_shift - {1'b0, dvs_q};
    trial_ok = ~p_trial[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      p_q        <= '0;
      sq_q       <= 1'b0;
      sr_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      quo_q      <= '0;
      rem_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (bus.start) begin
            if (bus.Rb == '0) begin
              quo_q      <= '1;
              rem_q      <= bus.Ra;
              div_zero_q <= 1'b1;
              done_q     <= 1'b1;
              state_q    <= StDone;
            end else begin
              dvd_q      <= ra_mag;
              dvs_q      <= rb_mag;
              sq_q       <= bus.Ra[WIDTH-1] ^ bus.Rb[WIDTH-1];
              sr_q       <= bus.Ra[WIDTH-1];
              p_q        <= '0;
              cnt_q      <= '0;
              div_zero_q <= 1'b0;
              busy_q     <= 1'b1;
              state_q    <= StCalc;
            end
          end
        end
        StCalc: begin
          p_q   <= trial_ok ? p_trial[WIDTH-1:0] : p_shift[WIDTH-1:0];
          dvd_q <= {dvd_q[WIDTH-2:0], trial_ok};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          quo_q   <= sq_q ? -dvd_q : dvd_q;
          rem_q   <= sr_q ? -p_q : p_q;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.div_zero  = div_zero_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;

endmodule

// File: tb/tb_div_32bit_seq.sv
// Directed bench for div_32bit_seq: expected results are queued when a
// request is driven and popped when done pulses.
module tb_div_32bit_seq;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } exp_t;

  logic clk;
  logic clr;
  int   checks;
  int   errors;
  exp_t sb[$];

  div_32bit_seq_if #(.WIDTH(32)) dut_if ();

  div_32bit_seq #(.WIDTH(32)) dut (
    .clk (clk),
    .clr (clr),
    .bus (dut_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent reference: language signed division, with the two special cases.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   sa;
    int   sbv;
    sa  = a;
    sbv = b;
    if (b == 32'd0) begin
      e.q = 32'hFFFFFFFF; e.r = a; e.dz = 1'b1;
    end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      e.q = 32'h80000000; e.r = 32'd0; e.dz = 1'b0;
    end else begin
      e.q = 32'(sa / sbv); e.r = 32'(sa % sbv); e.dz = 1'b0;
    end
    return e;
  endfunction

  // Returns at the negedge one cycle after the accepting edge.
  task automatic drive_start(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] eq, input logic [31:0] er, input logic edz);
    exp_t e;
    e.q = eq; e.r = er; e.dz = edz;
    @(negedge clk);
    dut_if.Ra    = a;
    dut_if.Rb    = b;
    dut_if.start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    dut_if.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat, input int inject_at);
    int   n;
    logic busy_bad;
    exp_t e;
    n = 1;
    busy_bad = 1'b0;
    while (!dut_if.done && n < 60) begin
      if (!dut_if.busy) busy_bad = 1'b1;
      if (n == inject_at) begin
        dut_if.Ra = 32'd1; dut_if.Rb = 32'd1; dut_if.start = 1'b1;
      end else begin
        dut_if.start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    dut_if.start = 1'b0;
    chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    if (exp_lat > 1) chk({tag, "_busy_during"}, {31'd0, busy_bad}, 32'd0);
    chk({tag, "_busy_at_done"}, {31'd0, dut_if.busy}, 32'd0);
    chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_quotient"}, dut_if.quotient, e.q);
      chk({tag, "_remainder"}, dut_if.remainder, e.r);
      chk({tag, "_div_zero"}, {31'd0, dut_if.div_zero}, {31'd0, e.dz});
    end
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, {31'd0, dut_if.done}, 32'd0);
  endtask

  task automatic quiet(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (dut_if.done) seen = 1'b1;
    end
    chk({tag, "_no_extra_done"}, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    exp_t e;
    logic [31:0] a;
    logic [31:0] b;
    checks = 0;
    errors = 0;
    clr = 1'b1;
    dut_if.start = 1'b0;
    dut_if.Ra = '0;
    dut_if.Rb = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, dut_if.busy}, 32'd0);
    chk("rst_done", {31'd0, dut_if.done}, 32'd0);
    chk("rst_div_zero", {31'd0, dut_if.div_zero}, 32'd0);
    chk("rst_quotient", dut_if.quotient, 32'd0);
    chk("rst_remainder", dut_if.remainder, 32'd0);
    clr = 1'b0;

    drive_start(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    wait_done("pos_100_7", 34, -1);
    drive_start(-32'd100, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
    wait_done("neg_dvd", 34, -1);
    drive_start(32'd100, -32'd7, 32'hFFFFFFF2, 32'd2, 1'b0);
    wait_done("neg_dvs", 34, -1);
    drive_start(-32'd100, -32'd7, 32'd14, 32'hFFFFFFFE, 1'b0);
    wait_done("neg_both", 34, -1);

    drive_start(32'd55, 32'd0, 32'hFFFFFFFF, 32'd55, 1'b1);
    wait_done("div_zero", 1, -1);
    drive_start(32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
    wait_done("after_dz_9_3", 34, -1);

    drive_start(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0);
    wait_done("min_by_m1", 34, -1);
    drive_start(32'h7FFFFFFF, 32'd1, 32'h7FFFFFFF, 32'd0, 1'b0);
    wait_done("max_by_1", 34, -1);
    drive_start(32'd3, 32'd10, 32'd0, 32'd3, 1'b0);
    wait_done("small_3_10", 34, -1);
    drive_start(32'h80000000, 32'd7, 32'hEDB6DB6E, 32'hFFFFFFFE, 1'b0);
    wait_done("min_by_7", 34, -1);

    // Second request during CALC must be ignored.
    drive_start(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    wait_done("start_busy", 34, 10);
    quiet("start_busy", 40);
    chk("start_busy_sb_empty", 32'(sb.size()), 32'd0);

    // Abort mid-operation with clr.
    drive_start(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    repeat (19) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("abort_busy", {31'd0, dut_if.busy}, 32'd0);
    chk("abort_done", {31'd0, dut_if.done}, 32'd0);
    chk("abort_quotient", dut_if.quotient, 32'd0);
    chk("abort_remainder", dut_if.remainder, 32'd0);
    quiet("abort", 40);
    sb.delete();
    drive_start(32'd50, 32'd5, 32'd10, 32'd0, 1'b0);
    wait_done("after_abort_50_5", 34, -1);

    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = (i == 5) ? 32'd0 : ($urandom >> (i * 5));
      e = model(a, b);
      drive_start(a, b, e.q, e.r, e.dz);
      wait_done("random", (b == 32'd0) ? 1 : 34, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
